// File: rtl/instruction_decode_hz.sv
// Decode stage for the 5-stage MIPS-subset pipeline.
// Holds the register file with write-first bypass, decodes control, forms the
// branch target, detects load-use hazards and registers everything into ID/EX.
module instruction_decode_hz #(
   parameter int DATA_WIDTH  = 32,
   parameter int PC_WIDTH    = 11,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic [31:0]            instruction,
   input  logic                   instr_valid,
   input  logic [PC_WIDTH-1:0]    current_pc,
   input  logic [DATA_WIDTH-1:0]  write_back_data,
   input  logic [REG_ADDR_W-1:0]  write_back_address,
   input  logic                   RegWrite,
   input  logic                   flush,
   input  logic [REG_ADDR_W-1:0]  dbg_addr,
   output logic [DATA_WIDTH-1:0]  dbg_data,
   output logic                   stall_out,
   output logic                   valid_out,
   output logic [DATA_WIDTH-1:0]  data_a,
   output logic [DATA_WIDTH-1:0]  data_b,
   output logic [DATA_WIDTH-1:0]  sign_extended,
   output logic [PC_WIDTH-1:0]    jump_dest_addr,
   output logic [REG_ADDR_W-1:0]  reg_dest_r_type,
   output logic [REG_ADDR_W-1:0]  reg_dest_l_type,
   output logic [REG_ADDR_W-1:0]  reg_dest_s_type,
   output logic [REG_ADDR_W-1:0]  sa,
   output logic                   RegDst_out,
   output logic                   ALUSrc_out,
   output logic                   MemToReg_out,
   output logic                   RegWrite_out,
   output logic                   MemRead_out,
   output logic                   MemWrite_out,
   output logic                   Branch_out,
   output logic [1:0]             ALUOp_out,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctl_t;

   logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];

   logic                   valid_q, valid_d;
   ctl_t                   ctl_q, ctl_d, ctl_dec;
   logic [DATA_WIDTH-1:0]  data_a_q, data_a_d;
   logic [DATA_WIDTH-1:0]  data_b_q, data_b_d;
   logic [DATA_WIDTH-1:0]  sext_q, sext_d;
   logic [PC_WIDTH-1:0]    jump_q, jump_d;
   logic [REG_ADDR_W-1:0]  rd_q, rd_d;
   logic [REG_ADDR_W-1:0]  rt_q, rt_d;
   logic [REG_ADDR_W-1:0]  rs_q, rs_d;
   logic [REG_ADDR_W-1:0]  sa_q, sa_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [REG_ADDR_W-1:0]  rs_addr, rt_addr, rd_addr, sa_field;
   logic [5:0]             opcode;
   logic                   wb_en;
   logic                   hz;

   assign opcode   = instruction[31:26];
   assign rs_addr  = instruction[21 +: REG_ADDR_W];
   assign rt_addr  = instruction[16 +: REG_ADDR_W];
   assign rd_addr  = instruction[11 +: REG_ADDR_W];
   assign sa_field = instruction[6 +: REG_ADDR_W];
   assign wb_en    = RegWrite && (write_back_address != '0);

   // Register file next state: write-back lands at the edge, r0 is never written
   always_comb begin
      regs_d = regs_q;
      if (wb_en) regs_d[write_back_address] = write_back_data;
   end

   // Register file storage; reset clears every entry
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Operand reads with same-cycle write-back bypass; r0 forced to zero
   always_comb begin
      data_a_d = regs_q[rs_addr];
      data_b_d = regs_q[rt_addr];
      if (wb_en && (write_back_address == rs_addr)) data_a_d = write_back_data;
      if (wb_en && (write_back_address == rt_addr)) data_b_d = write_back_data;
      if (rs_addr == '0) data_a_d = '0;
      if (rt_addr == '0) data_b_d = '0;
   end

   // Debug port sees the stored value only, never the bypass
   assign dbg_data = regs_q[dbg_addr];

   // Opcode to control decode; unknown opcodes behave as NOP
   always_comb begin
      ctl_dec = '0;
      unique case (opcode)
         6'h00: ctl_dec = '{reg_dst: 1'b1, reg_write: 1'b1, alu_op: 2'b10, default: '0};
         6'h23: ctl_dec = '{alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                            mem_read: 1'b1, alu_op: 2'b00, default: '0};
         6'h2B: ctl_dec = '{alu_src: 1'b1, mem_write: 1'b1, alu_op: 2'b00, default: '0};
         6'h04: ctl_dec = '{branch: 1'b1, alu_op: 2'b01, default: '0};
         6'h08: ctl_dec = '{alu_src: 1'b1, reg_write: 1'b1, alu_op: 2'b00, default: '0};
         default: ctl_dec = '0;
      endcase
   end

   // Load-use hazard against the load sitting in ID/EX; flush overrides the stall
   assign hz = instr_valid && valid_q && ctl_q.mem_read && (rt_q != '0) &&
               ((rt_q == rs_addr) || (rt_q == rt_addr));
   assign stall_out = hz && !flush;

   // ID/EX next state: flush or hazard loads a bubble, otherwise the decoded instruction
   always_comb begin
      sext_d = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
      // Only the low PC_WIDTH bits of the shifted offset reach the truncated sum
      jump_d = current_pc + {sext_d[PC_WIDTH-3:0], 2'b00};
      rd_d   = rd_addr;
      rt_d   = rt_addr;
      rs_d   = rs_addr;
      sa_d   = sa_field;
      valid_d = instr_valid;
      ctl_d   = instr_valid ? ctl_dec : '0;
      if (flush || hz) begin
         valid_d = 1'b0;
         ctl_d   = '0;
      end
      stall_cnt_d = stall_cnt_q;
      if (stall_out && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   // ID/EX pipeline register and stall counter
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         ctl_q       <= '0;
         data_a_q    <= '0;
         data_b_q    <= '0;
         sext_q      <= '0;
         jump_q      <= '0;
         rd_q        <= '0;
         rt_q        <= '0;
         rs_q        <= '0;
         sa_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         ctl_q       <= ctl_d;
         data_a_q    <= data_a_d;
         data_b_q    <= data_b_d;
         sext_q      <= sext_d;
         jump_q      <= jump_d;
         rd_q        <= rd_d;
         rt_q        <= rt_d;
         rs_q        <= rs_d;
         sa_q        <= sa_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign valid_out       = valid_q;
   assign data_a          = data_a_q;
   assign data_b          = data_b_q;
   assign sign_extended   = sext_q;
   assign jump_dest_addr  = jump_q;
   assign reg_dest_r_type = rd_q;
   assign reg_dest_l_type = rt_q;
   assign reg_dest_s_type = rs_q;
   assign sa              = sa_q;
   assign RegDst_out      = ctl_q.reg_dst;
   assign ALUSrc_out      = ctl_q.alu_src;
   assign MemToReg_out    = ctl_q.mem_to_reg;
   assign RegWrite_out    = ctl_q.reg_write;
   assign MemRead_out     = ctl_q.mem_read;
   assign MemWrite_out    = ctl_q.mem_write;
   assign Branch_out      = ctl_q.branch;
   assign ALUOp_out       = ctl_q.alu_op;
   assign stall_count     = stall_cnt_q;

endmodule
